// File: rtl/spi_slave_sync.sv
// SPI slave with clk-domain oversampling of SCLK/CS/MOSI, RX FIFO with
// sticky overrun flag, and a TX shadow register that is recirculated per word.
module spi_slave_sync #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_W       = 16,
    parameter int unsigned CPOL       = 0,
    parameter int unsigned CPHA       = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [TX_W-1:0]   tx_data,
    input  logic              tx_load,
    input  logic              rx_ovr_clr,
    output logic              rx_overrun,
    output logic              frame_active
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RXC_W = $clog2(DATA_W);
    localparam int unsigned TXC_W = $clog2(TX_W);
    localparam logic        SCLK_IDLE = (CPOL != 0);
    localparam logic        SAMPLE_TRAIL = (CPHA != 0);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,   // after reset: wait to see CS high before any frame
        ST_IDLE     = 2'd1,   // CS high, waiting for a falling edge
        ST_ACTIVE   = 2'd2    // frame in progress
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [1:0] sync_fill_q;

    logic sclk_rise;
    logic sclk_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_sync;
    logic cs_fall;
    logic mosi_sync;
    logic sync_primed;

    // Bring SCLK, CS and MOSI into the clk domain; sync_fill marks when the chains hold real pin values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= {3{SCLK_IDLE}};
            cs_q        <= 3'b111;
            mosi_q      <= 2'b00;
            sync_fill_q <= 2'b00;
        end else begin
            sclk_q      <= {sclk_q[1:0], spi_sclk};
            cs_q        <= {cs_q[1:0], spi_cs_n};
            mosi_q      <= {mosi_q[0], spi_mosi};
            sync_fill_q <= {sync_fill_q[0], 1'b1};
        end
    end

    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign lead_edge   = SCLK_IDLE ? sclk_fall : sclk_rise;
    assign trail_edge  = SCLK_IDLE ? sclk_rise : sclk_fall;
    assign sample_edge = SAMPLE_TRAIL ? trail_edge : lead_edge;
    assign shift_edge  = SAMPLE_TRAIL ? lead_edge : trail_edge;
    assign cs_sync     = cs_q[1];
    assign cs_fall     = ~cs_q[1] & cs_q[2];
    assign mosi_sync   = mosi_q[1];
    assign sync_primed = sync_fill_q[1];

    // ------------------------------------------------------------------
    // Frame control FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   frame_start;
    logic   frame_live;

    // State register and registered frame_active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DISARMED;
            frame_active <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_active <= (state_d == ST_ACTIVE);
        end
    end

    // Next-state: a frame only starts on a CS fall seen after CS was observed high
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            ST_DISARMED: begin
                if (sync_primed && cs_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    assign frame_live = (state_q == ST_ACTIVE) && !cs_sync;

    // ------------------------------------------------------------------
    // RX shifter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_shift_q;
    logic [RXC_W-1:0]  rx_cnt_q;
    logic [DATA_W-1:0] rx_word;
    logic              sample_evt;
    logic              push;

    assign sample_evt = frame_live && sample_edge;
    assign rx_word    = {rx_shift_q[DATA_W-2:0], mosi_sync};
    assign push       = sample_evt && (rx_cnt_q == RXC_W'(DATA_W - 1));

    // Shift MOSI in MSB first; a partial word is simply abandoned at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
        end else if (frame_start) begin
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
        end else if (sample_evt) begin
            rx_shift_q <= rx_word;
            if (push) begin
                rx_cnt_q <= '0;
            end else begin
                rx_cnt_q <= rx_cnt_q + RXC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              ovr_set;

    assign pop     = rx_valid && rx_ready;
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_en   = push && (!full || pop);
    assign ovr_set = push && full && !pop;
    assign rx_data = mem_q[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage, pointers, valid flag and sticky overrun (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= rx_word;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q  <= count_d;
            rx_valid <= (count_d != '0);
            if (ovr_set) begin
                rx_overrun <= 1'b1;
            end else if (rx_ovr_clr) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX shadow and shifter
    // ------------------------------------------------------------------
    logic [TX_W-1:0]  shadow_q;
    logic [TX_W-1:0]  shadow_d;
    logic [TX_W-1:0]  tx_shift_q;
    logic [TXC_W-1:0] tx_cnt_q;
    logic             tx_first_q;
    logic             shift_evt;

    // A load in the same cycle as a frame start or word boundary is the one used
    assign shadow_d  = tx_load ? tx_data : shadow_q;
    assign shift_evt = frame_live && shift_edge;

    // MISO is the registered MSB; words recirculate from the shadow at each boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_first_q <= 1'b0;
            spi_miso   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (frame_start) begin
                tx_shift_q <= shadow_d;
                tx_cnt_q   <= '0;
                tx_first_q <= SAMPLE_TRAIL;
                spi_miso   <= SAMPLE_TRAIL ? 1'b0 : shadow_d[TX_W-1];
            end else if (!frame_live) begin
                tx_cnt_q   <= '0;
                tx_first_q <= 1'b0;
                spi_miso   <= 1'b0;
            end else if (shift_evt) begin
                if (tx_first_q) begin
                    tx_first_q <= 1'b0;
                    spi_miso   <= tx_shift_q[TX_W-1];
                end else if (tx_cnt_q == TXC_W'(TX_W - 1)) begin
                    tx_shift_q <= shadow_d;
                    tx_cnt_q   <= '0;
                    spi_miso   <= shadow_d[TX_W-1];
                end else begin
                    tx_shift_q <= {tx_shift_q[TX_W-2:0], 1'b0};
                    tx_cnt_q   <= tx_cnt_q + TXC_W'(1);
                    spi_miso   <= tx_shift_q[TX_W-2];
                end
            end
        end
    end

endmodule
